out_port_arbiter: RTL and testbench
===================================

// Module: out_port_arbiter
// PURPOSE
//  Round-robin, packet-locking (wormhole) arbiter for one router output port. Collects
//  requests from the N/E/W/S/L input ports and drives the one-hot select that steers the
//  output crossbar mux for that port. One instance per output port, next to its xbar.
//  The grant is held from head flit to tail flit, then rotates fairly.
// PARAMETERS
//  NPORTS       5    number of requesters; fixed at 5 (N,E,W,S,L), not a true generic
//  TIMEOUT_CYC  255  locked cycles with the owner's req low before forced release; 0 = disabled
//  TO_W         8    width of the timeout counter; must hold TIMEOUT_CYC
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  asynchronous, active-low reset
//  req          in   5  per-input-port request for this output; bit order {L,S,W,E,N}
//  tail         in   5  flit presented by input i is a tail (single-flit packet: head=tail)
//  out_ready    in   1  downstream buffer can accept a flit this cycle
//  sel_out      out  5  one-hot select to xbar: `N_PORT/`E_PORT/`W_PORT/`S_PORT/`L_PORT or 0
//  grant_valid  out  1  sel_out is non-zero (state LOCK)
//  xfer         out  5  one-hot pulse: flit from port i moves this cycle (read-enable to input FIFO)
//  out_valid    out  1  |xfer; write-enable to downstream buffer
//  err_timeout  out  1  sticky; set on a forced release, cleared only by reset
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE, sel_out=0, grant_valid=0, ptr=N (bit 0),
//    timeout count=0, err_timeout=0. xfer/out_valid are combinational and therefore 0.
//  - States: IDLE, LOCK. sel_out, grant_valid and ptr are registered.
//  - IDLE: if req!=0, pick the first set bit scanning circularly from ptr upward
//    (N->E->W->S->L->N). Next cycle: LOCK, sel_out=that one-hot. If req==0, stay IDLE.
//  - Request latency: req seen in cycle n -> sel_out valid in cycle n+1.
//    The first transfer can happen in cycle n+1.
//  - LOCK, transfer rule (combinational): xfer = sel_out & req & {5{out_ready}}.
//    At most one bit of xfer is ever set.
//  - LOCK, transfer with tail of the owner set: next cycle IDLE, sel_out=0,
//    ptr = owner rotated left by 1 (L wraps to N).
//    One-cycle bubble before the next grant (IDLE re-arbitrates).
//  - LOCK, transfer without tail: stay LOCK, same owner (mid-packet).
//  - LOCK, owner req low: hold the lock, no transfer, timeout count += 1.
//    Requests from other ports are ignored for the whole lock.
//  - LOCK, owner req high: timeout count = 0, whether or not out_ready.
//    Backpressure alone never triggers a timeout.
//  - Forced release: TIMEOUT_CYC != 0 and count reaches TIMEOUT_CYC -> next cycle IDLE,
//    sel_out=0, ptr rotated past the owner, err_timeout=1, count=0.
//  - Count saturates at TIMEOUT_CYC and never wraps. Count is 0 in IDLE.
//  - Requests of non-owners never change the state while locked.
//  - Reset asserted mid-packet: immediate return to the reset values.
//    Partial-packet cleanup belongs to the input buffers.
//  - Invariant: sel_out is 0 or exactly one-hot, never multi-hot.
//    The xbar drives its output data to 0 when sel_out is 0.
// STRUCTURE
//  - Port one-hot codes (`N_PORT=5'b00001, `E_PORT=5'b00010, `W_PORT=5'b00100,
//    `S_PORT=5'b01000, `L_PORT=5'b10000) and the state encodings (IDLE=1'b0, LOCK=1'b1)
//    live in the shared include state_defines.v; widths live in parameters.v.
//  - One sub-module, rr_pick5: combinational circular priority picker
//    (req[4:0], ptr[4:0] -> one-hot gnt[4:0]). Reused by the VC allocator.
//  - Top level holds the FSM, the ptr register, the timeout counter and the xfer logic.
// TESTING
//  1. Reset: rst=0 with req=5'h1F -> sel_out=0, grant_valid=0, xfer=0, err_timeout=0.
//     Release rst with req=5'h1F, out_ready=1 -> sel_out=5'b00001 one cycle later.
//  2. Fairness: req=5'h1F, every flit a tail, out_ready=1 held -> grant order
//     N,E,W,S,L,N with exactly one IDLE bubble cycle between consecutive grants.
//  3. Packet lock: E sends a 4-flit packet (tail on flit 4) while N and L request ->
//     sel_out stays 5'b00010 for all 4 transfers.
//     Next grant goes to L (ptr=W; scan W,S,L), not N.
//  4. Backpressure: locked to W, out_ready=0 for 10 cycles with req[2]=1 ->
//     xfer=0 throughout, sel_out stays 5'b00100, err_timeout stays 0.
//     Resume with out_ready=1 -> transfers continue.
//  5. Timeout: TIMEOUT_CYC=4, locked to S, req[3] dropped ->
//     release after 4 low cycles: sel_out=0, err_timeout=1 (sticky), then ptr=L.
//  6. Async reset mid-packet: rst pulled low between clock edges while locked to L ->
//     sel_out=0 immediately, before the next edge. After release, N wins arbitration first.

Source files
------------

// File: rtl/out_port_arbiter_pkg.sv
// Shared port codes, FSM states and helpers for the router output-port arbiter
// and the circular picker it shares with the VC allocator.
package out_port_arbiter_pkg;

    localparam int NPORTS = 5;

    localparam logic [NPORTS-1:0] N_PORT = 5'b00001;
    localparam logic [NPORTS-1:0] E_PORT = 5'b00010;
    localparam logic [NPORTS-1:0] W_PORT = 5'b00100;
    localparam logic [NPORTS-1:0] S_PORT = 5'b01000;
    localparam logic [NPORTS-1:0] L_PORT = 5'b10000;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Next port in N->E->W->S->L->N order; L wraps to N.
    function automatic logic [NPORTS-1:0] rotl1(input logic [NPORTS-1:0] v);
        return {v[NPORTS-2:0], v[NPORTS-1]};
    endfunction

endpackage

// File: rtl/out_port_arbiter_if.sv
// Request/steering bundle between the input ports and one output-port arbiter.
interface out_port_arbiter_if;
    import out_port_arbiter_pkg::*;

    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] tail;
    logic              out_ready;
    logic [NPORTS-1:0] sel_out;
    logic              grant_valid;
    logic [NPORTS-1:0] xfer;
    logic              out_valid;
    logic              err_timeout;

    modport master (
        output req, tail, out_ready,
        input  sel_out, grant_valid, xfer, out_valid, err_timeout
    );

    modport slave (
        input  req, tail, out_ready,
        output sel_out, grant_valid, xfer, out_valid, err_timeout
    );

endinterface

// File: rtl/out_port_arbiter_rr_pick5.sv
// Combinational circular priority picker: first set req bit at or after the
// one-hot ptr, wrapping L->N. Output is one-hot or zero.
module rr_pick5
    import out_port_arbiter_pkg::*;
(
    input  logic [NPORTS-1:0] i_req,
    input  logic [NPORTS-1:0] i_ptr,
    output logic [NPORTS-1:0] o_gnt
);

    // Scan farthest-first so the candidate nearest ptr overwrites the rest.
    always_comb begin
        o_gnt = '0;
        for (int s = 0; s < NPORTS; s++) begin
            if (i_ptr[s]) begin
                for (int k = NPORTS - 1; k >= 0; k--) begin
                    if (i_req[(s + k) % NPORTS]) begin
                        o_gnt                      = '0;
                        o_gnt[(s + k) % NPORTS]    = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Wormhole output-port arbiter: round-robin pick in IDLE, grant held head to
// tail in LOCK, forced release if the owner stalls its request too long.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    out_port_arbiter_if.slave  bus
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

    arb_state_e        r_state, w_state_nxt;
    logic [NPORTS-1:0] r_sel, w_sel_nxt;
    logic [NPORTS-1:0] r_ptr, w_ptr_nxt;
    logic [TO_W-1:0]   r_cnt, w_cnt_nxt;
    logic              r_err, w_err_nxt;

    logic [NPORTS-1:0] w_gnt;
    logic [NPORTS-1:0] w_xfer;
    logic              w_own_req;
    logic              w_tail_xfer;
    logic [TO_W-1:0]   w_cnt_inc;
    logic              w_to_hit;

    rr_pick5 u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    assign w_xfer      = r_sel & bus.req & {NPORTS{bus.out_ready}};
    assign w_own_req   = |(r_sel & bus.req);
    assign w_tail_xfer = |(w_xfer & bus.tail);

    // Saturating count of owner-idle cycles; stuck at 0 when timeout is disabled.
    assign w_cnt_inc = (r_cnt == TO_LIM) ? r_cnt : r_cnt + 1'b1;
    assign w_to_hit  = (TIMEOUT_CYC != 0) && (w_cnt_inc == TO_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= N_PORT;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (|bus.req) begin
                    w_state_nxt = LOCK;
                    w_sel_nxt   = w_gnt;
                end
            end
            LOCK: begin
                if (w_tail_xfer) begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = '0;
                    w_ptr_nxt   = rotl1(r_sel);
                    w_cnt_nxt   = '0;
                end else if (w_own_req) begin
                    // Backpressure with the owner still requesting is not a stall.
                    w_cnt_nxt = '0;
                end else if (w_to_hit) begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = '0;
                    w_ptr_nxt   = rotl1(r_sel);
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = '0;
            end
        endcase
    end

    assign bus.sel_out     = r_sel;
    assign bus.grant_valid = (r_state == LOCK);
    assign bus.xfer        = w_xfer;
    assign bus.out_valid   = |w_xfer;
    assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed scenarios plus random traffic for out_port_arbiter, checked each
// cycle against a packet-level model (owner index, pointer, idle-cycle count).
module tb_out_port_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    out_port_arbiter_if bus ();

    out_port_arbiter #(.TIMEOUT_CYC(TO), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int m_own = -1;   // index of the port holding the lock, -1 when free
    int m_ptr = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;

    logic [4:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [4:0] r, input int p);
        for (int k = 0; k < 5; k++)
            if (r[(p + k) % 5]) return (p + k) % 5;
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
    endtask

    // One clock cycle: drive inputs, check every output against the model, advance.
    task automatic cyc(input logic [4:0] rq, input logic [4:0] tl, input logic rd);
        logic [4:0] e_sel;
        logic [4:0] e_xfer;
        bus.req = rq; bus.tail = tl; bus.out_ready = rd;
        #2;
        e_sel = '0;
        if (m_own >= 0) e_sel[m_own] = 1'b1;
        e_xfer = (m_own >= 0 && rq[m_own] && rd) ? e_sel : 5'b0;
        chk("sel_out",     32'(bus.sel_out),     32'(e_sel));
        chk("grant_valid", 32'(bus.grant_valid), 32'(m_own >= 0));
        chk("xfer",        32'(bus.xfer),        32'(e_xfer));
        chk("out_valid",   32'(bus.out_valid),   32'(e_xfer != 0));
        chk("err_timeout", 32'(bus.err_timeout), 32'(m_err));
        if (m_own < 0) begin
            if (rq != 0) m_own = pick(rq, m_ptr);
            m_cnt = 0;
        end else if (rq[m_own] && rd) begin
            if (tl[m_own]) begin
                m_ptr = (m_own + 1) % 5;
                m_own = -1;
            end
            m_cnt = 0;
        end else if (rq[m_own]) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt >= TO) begin
                m_ptr = (m_own + 1) % 5;
                m_own = -1;
                m_err = 1'b1;
                m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_order [6];
        exp_order = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

        // Reset with every port requesting.
        bus.req = 5'h1F; bus.tail = 5'h00; bus.out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel",   32'(bus.sel_out),     32'h0);
        chk("rst_gv",    32'(bus.grant_valid), 32'h0);
        chk("rst_xfer",  32'(bus.xfer),        32'h0);
        chk("rst_err",   32'(bus.err_timeout), 32'h0);
        rst = 1'b1;

        // Fairness: single-flit packets from everyone.
        for (int i = 0; i < 12; i++) begin
            cyc(5'h1F, 5'h1F, 1'b1);
            if (i == 0) chk("first_grant", 32'(bus.sel_out), 32'h01);
            if (bus.sel_out != 0) got_q.push_back(bus.sel_out);
        end
        chk("fair_len", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            chk("fair_order", 32'(got_q[i]), 32'(exp_order[i]));

        // Packet lock: E sends 4 flits while N and L also request.
        cyc(5'b10011, 5'b00000, 1'b1);
        for (int f = 1; f <= 4; f++) begin
            chk("lock_E", 32'(bus.sel_out), 32'h02);
            cyc(5'b10011, (f == 4) ? 5'b00010 : 5'b00000, 1'b1);
        end
        cyc(5'b10001, 5'b00000, 1'b1);
        chk("after_E_to_L", 32'(bus.sel_out), 32'h10);
        cyc(5'b10000, 5'b10000, 1'b1);

        // Backpressure while locked to W.
        cyc(5'b00100, 5'b00000, 1'b1);
        for (int i = 0; i < 10; i++) cyc(5'b00100, 5'b00000, 1'b0);
        chk("bp_sel",  32'(bus.sel_out),     32'h04);
        chk("bp_xfer", 32'(bus.xfer),        32'h00);
        chk("bp_err",  32'(bus.err_timeout), 32'h0);
        cyc(5'b00100, 5'b00000, 1'b1);
        chk("bp_resume", 32'(bus.sel_out), 32'h04);
        cyc(5'b00100, 5'b00100, 1'b1);

        // Timeout: S drops its request mid-packet.
        cyc(5'b01000, 5'b00000, 1'b1);
        for (int i = 0; i < 3; i++) cyc(5'b00000, 5'b00000, 1'b1);
        chk("to_hold", 32'(bus.sel_out), 32'h08);
        cyc(5'b00000, 5'b00000, 1'b1);
        chk("to_sel", 32'(bus.sel_out),     32'h00);
        chk("to_err", 32'(bus.err_timeout), 32'h1);
        cyc(5'h1F, 5'b00000, 1'b1);
        chk("to_next_L", 32'(bus.sel_out), 32'h10);
        chk("to_sticky", 32'(bus.err_timeout), 32'h1);

        // Async reset mid-packet while locked to L.
        cyc(5'b10000, 5'b00000, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_sel", 32'(bus.sel_out),     32'h00);
        chk("arst_gv",  32'(bus.grant_valid), 32'h0);
        chk("arst_err", 32'(bus.err_timeout), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(5'h1F, 5'b00000, 1'b1);
        chk("arst_first_N", 32'(bus.sel_out), 32'h01);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rq, tl;
            logic       rd;
            rq = 5'($urandom);
            tl = 5'($urandom) & 5'($urandom);
            rd = ($urandom % 4) != 0;
            cyc(rq, tl, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
